// File: rtl/id_pkg.sv
// Shared widths, buffer occupancy encoding and decoded-instruction layout for the decode stage.
package id_pkg;

    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned OPC_W_DEF   = 4;
    localparam int unsigned MOP_W_DEF   = 4;

    // Struct fields are sized for the widest supported build; narrower builds use the low bits.
    localparam int unsigned OPC_W_MAX  = 8;
    localparam int unsigned MOP_W_MAX  = 8;
    localparam int unsigned OPND_W_MAX = 32;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2
    } occ_e;

    typedef struct packed {
        logic [OPC_W_MAX-1:0]  op;
        logic [MOP_W_MAX-1:0]  mop;
        logic [OPND_W_MAX-1:0] operand;
        logic                  is_mem;
        logic                  illegal;
    } dec_instr_t;

endpackage

// File: rtl/id_field_split.sv
// Combinational split of a raw instruction word into opcode, memory-op and operand fields.
module id_field_split import id_pkg::*; #(
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned OPC_W   = OPC_W_DEF,
    parameter int unsigned MOP_W   = MOP_W_DEF,
    parameter logic [2**OPC_W-1:0] ILLEGAL_MASK = '0
) (
    input  logic [INSTR_W-1:0] instr,
    output dec_instr_t         dec
);

    localparam int unsigned OPND_W = INSTR_W - OPC_W - MOP_W;

    logic [OPC_W-1:0]  op;
    logic [MOP_W-1:0]  mop;
    logic [OPND_W-1:0] opnd;

    assign op   = instr[INSTR_W-1 -: OPC_W];
    assign mop  = instr[INSTR_W-OPC_W-1 -: MOP_W];
    assign opnd = instr[OPND_W-1:0];

    always_comb begin
        dec                    = '0;
        dec.op[OPC_W-1:0]      = op;
        dec.mop[MOP_W-1:0]     = mop;
        dec.operand[OPND_W-1:0] = opnd;
        dec.is_mem             = |mop;
        dec.illegal            = ILLEGAL_MASK[op];
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field split at the input feeding a two-entry skid buffer with
// registered upstream ready and a delivered-instruction counter.
module id_stage import id_pkg::*; #(
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned OPC_W   = OPC_W_DEF,
    parameter int unsigned MOP_W   = MOP_W_DEF,
    parameter logic [2**OPC_W-1:0] ILLEGAL_MASK = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  id_ce,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [INSTR_W-1:0]                    instr,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OPC_W-1:0]                      op_code,
    output logic [MOP_W-1:0]                      mem_op,
    output logic [INSTR_W-OPC_W-MOP_W-1:0]        operand,
    output logic [(INSTR_W-OPC_W-MOP_W)/2-1:0]    left_operand,
    output logic [(INSTR_W-OPC_W-MOP_W)/2-1:0]    right_operand,
    output logic                                  is_mem,
    output logic                                  illegal,
    output logic [15:0]                           dec_cnt
);

    localparam int unsigned OPND_W = INSTR_W - OPC_W - MOP_W;
    localparam int unsigned HALF_W = OPND_W / 2;

    if (INSTR_W < OPC_W + MOP_W + 2 || (OPND_W % 2) != 0 || OPC_W > OPC_W_MAX ||
        MOP_W > MOP_W_MAX || OPND_W > OPND_W_MAX) begin : g_bad_widths
        $error("id_stage: operand width must be even, at least 2, and fit the decoded struct");
    end

    occ_e       state_q, state_d;
    dec_instr_t in_dec;
    dec_instr_t out_q, out_d;
    dec_instr_t skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic [15:0] cnt_q;
    logic       accept, deliver;
    logic       unused_bits;

    id_field_split #(
        .INSTR_W      (INSTR_W),
        .OPC_W        (OPC_W),
        .MOP_W        (MOP_W),
        .ILLEGAL_MASK (ILLEGAL_MASK)
    ) u_field_split (
        .instr (instr),
        .dec   (in_dec)
    );

    assign accept    = in_valid & in_ready_q;
    assign deliver   = out_valid & out_ready;
    assign out_valid = (state_q != OccEmpty);
    assign in_ready  = in_ready_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OccEmpty;
        end else begin
            case (state_q)
                OccEmpty: begin
                    if (accept) begin
                        out_d   = in_dec;
                        state_d = OccOne;
                    end
                end
                OccOne: begin
                    if (accept && deliver) begin
                        out_d = in_dec;
                    end else if (accept) begin
                        skid_d  = in_dec;
                        state_d = OccTwo;
                    end else if (deliver) begin
                        state_d = OccEmpty;
                    end
                end
                OccTwo: begin
                    if (deliver) begin
                        out_d   = skid_q;
                        state_d = OccOne;
                    end
                end
                default: state_d = OccEmpty;
            endcase
        end
        // Ready is a flop: decided from the next occupancy, never from this cycle's out_ready path.
        in_ready_d = id_ce & (state_d != OccTwo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OccEmpty;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            if (deliver && !flush) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign op_code       = out_q.op[OPC_W-1:0];
    assign mem_op        = out_q.mop[MOP_W-1:0];
    assign operand       = out_q.operand[OPND_W-1:0];
    assign left_operand  = out_q.operand[OPND_W-1 -: HALF_W];
    assign right_operand = out_q.operand[HALF_W-1:0];
    assign is_mem        = out_q.is_mem;
    assign illegal       = out_q.illegal;
    assign dec_cnt       = cnt_q;

    // Upper struct bits are zero padding in narrow builds.
    assign unused_bits = ^{out_q, skid_q};

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expected decodes, a monitor pops on delivery.
module tb_id_stage;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] mop;
        logic [7:0] opnd;
        logic [3:0] l;
        logic [3:0] r;
        logic       m;
        logic       il;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, id_ce, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] instr;
    logic [3:0]  op_code, mem_op, left_operand, right_operand;
    logic [7:0]  operand;
    logic        is_mem, illegal;
    logic [15:0] dec_cnt;

    logic        id_ce24, flush24, in_valid24, in_ready24, out_valid24, out_ready24;
    logic [23:0] instr24;
    logic [3:0]  op_code24, mem_op24;
    logic [15:0] operand24;
    logic [7:0]  left24, right24;
    logic        is_mem24, illegal24;
    logic [15:0] dec_cnt24;

    exp_t got_w;
    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign got_w = {op_code, mem_op, operand, left_operand, right_operand, is_mem, illegal};

    id_stage #(
        .INSTR_W      (16),
        .OPC_W        (4),
        .MOP_W        (4),
        .ILLEGAL_MASK (16'h8000)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_ce         (id_ce),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op_code       (op_code),
        .mem_op        (mem_op),
        .operand       (operand),
        .left_operand  (left_operand),
        .right_operand (right_operand),
        .is_mem        (is_mem),
        .illegal       (illegal),
        .dec_cnt       (dec_cnt)
    );

    id_stage #(
        .INSTR_W (24),
        .OPC_W   (4),
        .MOP_W   (4)
    ) u_dut24 (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_ce         (id_ce24),
        .flush         (flush24),
        .in_valid      (in_valid24),
        .in_ready      (in_ready24),
        .instr         (instr24),
        .out_valid     (out_valid24),
        .out_ready     (out_ready24),
        .op_code       (op_code24),
        .mem_op        (mem_op24),
        .operand       (operand24),
        .left_operand  (left24),
        .right_operand (right24),
        .is_mem        (is_mem24),
        .illegal       (illegal24),
        .dec_cnt       (dec_cnt24)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [3:0] mop,
                                input logic [7:0] opnd, input logic [3:0] l,
                                input logic [3:0] r, input logic m, input logic il);
        return {op, mop, opnd, l, r, m, il};
    endfunction

    // Reference decode for bulk traffic; opcode F is the only illegal one in this build.
    function automatic exp_t model(input logic [15:0] w);
        return mk(w[15:12], w[11:8], w[7:0], w[7:4], w[3:0], |w[11:8], w[15:12] == 4'hF);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h required none", got_w);
            end else begin
                mon_e = q.pop_front();
                chk("deliver", 64'(got_w), 64'(mon_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] w, input exp_t e);
        int  n    = 0;
        bit  done = 1'b0;
        in_valid = 1'b1;
        instr    = w;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1'b1;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; id_ce = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        id_ce24 = 1'b1; flush24 = 1'b0; in_valid24 = 1'b0; instr24 = '0; out_ready24 = 1'b0;

        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_dec_cnt", 64'(dec_cnt), 64'(0));
        chk("reset_fields", 64'(got_w), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 64'(in_ready), 64'(1));

        // 24-bit build decode
        in_valid24 = 1'b1;
        instr24    = 24'hABCDEF;
        tick();
        in_valid24 = 1'b0;
        chk("w24_valid", 64'(out_valid24), 64'(1));
        chk("w24_fields", 64'({op_code24, mem_op24, operand24, left24, right24, is_mem24, illegal24}),
            64'({4'hA, 4'hB, 16'hCDEF, 8'hCD, 8'hEF, 1'b1, 1'b0}));

        // Single instruction, one-cycle latency
        out_ready = 1'b1;
        send(16'h3A5C, mk(4'h3, 4'hA, 8'h5C, 4'h5, 4'hC, 1'b1, 1'b0));
        chk("latency_valid", 64'(out_valid), 64'(1));
        chk("cnt_before", 64'(dec_cnt), 64'(0));
        drain();
        chk("cnt_one", 64'(dec_cnt), 64'(1));

        // Fill both entries with downstream stalled
        out_ready = 1'b0;
        send(16'h1000, mk(4'h1, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        send(16'h2000, mk(4'h2, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        chk("full_not_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b1;
        instr    = 16'h3000;
        repeat (3) tick();
        chk("full_stay_not_ready", 64'(in_ready), 64'(0));
        chk("hold_stable", 64'(got_w), 64'(mk(4'h1, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0)));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(16'h3000, mk(4'h3, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        drain();
        chk("cnt_four", 64'(dec_cnt), 64'(4));

        // Flush while full, with a competing offer
        out_ready = 1'b0;
        send(16'h4000, mk(4'h4, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        send(16'h5000, mk(4'h5, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = 16'h6000;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        chk("flush_cnt", 64'(dec_cnt), 64'(4));
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_no_deliver", 64'(dec_cnt), 64'(4));

        // Illegal / memory-op flags
        send(16'hF000, mk(4'hF, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1));
        send(16'hE100, mk(4'hE, 4'h1, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0));
        drain();
        chk("cnt_six", 64'(dec_cnt), 64'(6));

        // Decoder disable: acceptance stops, buffered entries drain
        out_ready = 1'b0;
        send(16'h7123, mk(4'h7, 4'h1, 8'h23, 4'h2, 4'h3, 1'b1, 1'b0));
        send(16'h8456, mk(4'h8, 4'h4, 8'h56, 4'h5, 4'h6, 1'b1, 1'b0));
        id_ce = 1'b0;
        tick();
        chk("ce_low_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        drain();
        chk("ce_low_drained_ready", 64'(in_ready), 64'(0));
        chk("cnt_eight", 64'(dec_cnt), 64'(8));
        id_ce = 1'b1;
        tick();
        chk("ce_high_ready", 64'(in_ready), 64'(1));

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(16'h9000, mk(4'h9, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        send(16'hA000, mk(4'hA, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'(0));
        chk("async_fields", 64'(got_w), 64'(0));
        chk("async_cnt", 64'(dec_cnt), 64'(0));
        chk("async_in_ready", 64'(in_ready), 64'(0));
        q.delete();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("post_reset_empty", 64'(out_valid), 64'(0));
        chk("post_reset_cnt", 64'(dec_cnt), 64'(0));

        // Counter wrap
        for (int i = 0; i < 65535; i++) begin
            send(16'(i), model(16'(i)));
        end
        drain();
        chk("cnt_ffff", 64'(dec_cnt), 64'(16'hFFFF));
        send(16'h1234, model(16'h1234));
        drain();
        chk("cnt_wrap", 64'(dec_cnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter INSTR_W, default 16: instruction word width in bits.
REQ-002 Parameter OPC_W, default 4: opcode field width, taken from the instruction MSBs.
REQ-003 Parameter MOP_W, default 4: memory-operation field width, directly below the opcode.
REQ-004 Parameter ILLEGAL_MASK, width 2**OPC_W, default all-zero: bit n set marks opcode n illegal.
REQ-005 Derived OPND_W = INSTR_W-OPC_W-MOP_W; elaboration SHALL fail if OPND_W is odd or below 2.
REQ-006 CLK  input  1  single clock; all state on rising edge.
REQ-007 RST_N  input  1  asynchronous, active-low reset.
REQ-008 ID_CE  input  1  decoder enable; low blocks acceptance only.
REQ-009 FLUSH  input  1  synchronous discard of all buffered instructions.
REQ-010 IN_VALID / IN_READY  input / output  1 / 1  upstream handshake.
REQ-011 INSTR  input  INSTR_W  raw instruction word.
REQ-012 OUT_VALID / OUT_READY  output / input  1 / 1  downstream handshake.
REQ-013 OP_CODE, MEM_OP, OPERAND  output  OPC_W, MOP_W, OPND_W  decoded fields.
REQ-014 LEFT_OPERAND / RIGHT_OPERAND  output  OPND_W/2 each  upper / lower half of OPERAND (destination / source for memory ops).
REQ-015 IS_MEM  output  1  MEM_OP non-zero; ILLEGAL  output  1  ILLEGAL_MASK[OP_CODE].
REQ-016 DEC_CNT  output  16  count of instructions delivered downstream.

Function
REQ-017 Field split SHALL be OP_CODE=INSTR[MSB -: OPC_W], MEM_OP next MOP_W bits, OPERAND the remaining LSBs.
REQ-018 Block SHALL hold a two-entry buffer (output register + skid register) with occupancy states EMPTY, ONE, TWO.
REQ-019 IN_READY SHALL be registered and equal ID_CE_q AND (state != TWO); no combinational path from OUT_READY to IN_READY.
REQ-020 Accept = IN_VALID & IN_READY; deliver = OUT_VALID & OUT_READY; OUT_VALID = (state != EMPTY).
REQ-021 Latency: instruction accepted in cycle N appears on outputs in cycle N+1 when EMPTY, or once ahead of it delivers.
REQ-022 Transitions: EMPTY->ONE on accept; ONE->TWO on accept w/o deliver; ONE->EMPTY on deliver w/o accept; TWO->ONE on deliver; accept+deliver in ONE stays ONE.
REQ-023 Output order SHALL equal acceptance order; no drop, no duplicate.
REQ-024 Output fields SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 FLUSH SHALL force EMPTY next cycle, override a same-cycle accept, and not increment DEC_CNT.
REQ-026 ID_CE low SHALL deassert IN_READY from next cycle; buffered entries still drain.
REQ-027 DEC_CNT SHALL increment by 1 per deliver and wrap 16'hFFFF->16'h0000.

Reset
REQ-028 RST_N low SHALL asynchronously force EMPTY, OUT_VALID=0, IN_READY=0, DEC_CNT=0, all field outputs 0.
REQ-029 First cycle after RST_N release: IN_READY follows ID_CE; reset mid-transfer discards all held instructions.

Structure
REQ-030 Package id_pkg SHALL hold default widths, occupancy-state enum, and decoded-instruction struct {op, mop, operand, is_mem, illegal}.
REQ-031 Sub-module id_field_split (combinational INSTR -> struct) SHALL be instantiated once, at the input, so buffer stores decoded structs.

Verification
REQ-032 Reset, ID_CE=1, OUT_READY=1, INSTR=16'h3A5C accepted -> next cycle OP_CODE=3, MEM_OP=A, OPERAND=5C, LEFT=5, RIGHT=C, IS_MEM=1, DEC_CNT 0->1.
REQ-033 OUT_READY=0, offer 16'h1000, 16'h2000, 16'h3000 back-to-back -> IN_READY low after 2 accepts; release OUT_READY -> outputs 1,2,3 in order, DEC_CNT=3.
REQ-034 State TWO plus FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, DEC_CNT unchanged.
REQ-035 ILLEGAL_MASK=16'h8000, INSTR=16'hF000 -> ILLEGAL=1, IS_MEM=0; INSTR=16'hE100 -> ILLEGAL=0, IS_MEM=1.
REQ-036 RST_N pulsed low mid-cycle while state TWO -> outputs zero immediately, nothing delivered after release.
REQ-037 Preload DEC_CNT to 16'hFFFF via 65535 delivers, one more deliver -> DEC_CNT=0; INSTR_W=24 build decodes 24'hABCDEF -> OP=A, MOP=B, OPERAND=CDEF, LEFT=CD, RIGHT=EF.
